// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one valid/ready command to a registered ALU.
// It waits for the result flag of the command's opcode group.
// It then returns the selected result bus on a valid/ready response channel.
// Optional build macro: ALU_SEQ_DIV0_CHECK_EN. When it is defined, a divide by
// zero (fun 0011, b 0) is answered with an error instead of being issued.
module alu_cmd_sequencer #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [WIDTH-1:0]   cmd_a,
   input  logic [WIDTH-1:0]   cmd_b,
   input  logic [3:0]         cmd_fun,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [3:0]         alu_fun,
   input  logic [2*WIDTH-1:0] alu_arith_out,
   input  logic [2*WIDTH-1:0] alu_logic_out,
   input  logic [2*WIDTH-1:0] alu_cmp_out,
   input  logic [2*WIDTH-1:0] alu_shift_out,
   input  logic               alu_carry,
   input  logic [3:0]         alu_flags,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_data,
   output logic               rsp_carry,
   output logic [3:0]         rsp_fun,
   output logic               rsp_err
);

   localparam int unsigned RW      = 2 * WIDTH;
   localparam int unsigned CNT_MAX = ALU_LAT + TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          div0_q, div0_d;
   logic          is_div0_c;

   logic          cmd_ready_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d;
   logic [3:0]    alu_fun_d;
   logic          rsp_valid_d, rsp_carry_d, rsp_err_d;
   logic [RW-1:0] rsp_data_d;
   logic [3:0]    rsp_fun_d;

   logic          sel_flag;
   logic [RW-1:0] sel_bus;

`ifdef ALU_SEQ_DIV0_CHECK_EN
   assign is_div0_c = (cmd_fun == 4'b0011) && (cmd_b == '0);
`else
   assign is_div0_c = 1'b0;
`endif

   // Pick the result flag and bus belonging to the issued opcode group
   always_comb begin
      sel_flag = alu_flags[alu_fun[3:2]];
      case (alu_fun[3:2])
         2'b00:   sel_bus = alu_arith_out;
         2'b01:   sel_bus = alu_logic_out;
         2'b10:   sel_bus = alu_cmp_out;
         default: sel_bus = alu_shift_out;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div0_q    <= 1'b0;
         cmd_ready <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_fun   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div0_q    <= div0_d;
         cmd_ready <= cmd_ready_d;
         alu_a     <= alu_a_d;
         alu_b     <= alu_b_d;
         alu_fun   <= alu_fun_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_carry <= rsp_carry_d;
         rsp_fun   <= rsp_fun_d;
         rsp_err   <= rsp_err_d;
      end
   end

   // Next-state and next-output logic: accept, wait/sample ALU, respond
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div0_d      = div0_q;
      cmd_ready_d = cmd_ready;
      alu_a_d     = alu_a;
      alu_b_d     = alu_b;
      alu_fun_d   = alu_fun;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      rsp_carry_d = rsp_carry;
      rsp_fun_d   = rsp_fun;
      rsp_err_d   = rsp_err;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_WAIT;
               div0_d      = is_div0_c;
               // A rejected op leaves the ALU inputs untouched
               if (!is_div0_c) begin
                  alu_a_d   = cmd_a;
                  alu_b_d   = cmd_b;
                  alu_fun_d = cmd_fun;
               end
            end
         end

         S_WAIT: begin
            if (div0_q) begin
               div0_d      = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_carry_d = 1'b0;
               rsp_fun_d   = 4'b0011;
               rsp_err_d   = 1'b1;
            end else if (cnt_q >= CW'(ALU_LAT)) begin
               if (sel_flag) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = sel_bus;
                  rsp_carry_d = (alu_fun[3:2] == 2'b00) ? alu_carry : 1'b0;
                  rsp_fun_d   = alu_fun;
                  rsp_err_d   = 1'b0;
               end else if (cnt_q == CW'(CNT_MAX)) begin
                  // Nominal sample plus TIMEOUT retries all missed the flag
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_carry_d = 1'b0;
                  rsp_fun_d   = alu_fun;
                  rsp_err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
